// File: rtl/pipeline_hazard_control_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM states, opcodes, control bundle.
package pipeline_hazard_control_pkg;

  // 2-bit sequencer state encoding
  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StDrain   = 2'd2,
    StHalted  = 2'd3
  } state_e;

  // Opcodes of the instructions whose behaviour this block sequences
  localparam logic [3:0] OpLw  = 4'h8;
  localparam logic [3:0] OpSw  = 4'h9;
  localparam logic [3:0] OpHlt = 4'hf;

  // Every pipeline-register control strobe the sequencer produces in one cycle
  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic de_en;
    logic xm_en;
    logic mw_en;
    logic fd_flush;
    logic de_flush;
    logic mw_flush;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_control_hazard_detect.sv
// Combinational load-use comparator between the decode sources and the load in DE.
module pipeline_hazard_control_hazard_detect (
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       de_mem_read,
  input  logic [3:0] de_write_reg,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == de_write_reg);
  assign rt_hit = id_uses_rt && (id_rt == de_write_reg);
  // r0 is hardwired zero, so a load into it never creates a dependency
  assign load_use = de_mem_read && (de_write_reg != 4'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_control.sv
// Central sequencer for the FD/DE/XM/MW pipeline registers and the PC.
module pipeline_hazard_control
  import pipeline_hazard_control_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             de_mem_read,
  input  logic [3:0]       de_write_reg,
  input  logic             branch_taken,
  input  logic             hlt_xm,
  input  logic             mem_req_xm,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             mw_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]  cnt_q;
  ctrl_t             ctrl;
  logic              load_use;
  logic              mem_stall;

  pipeline_hazard_control_hazard_detect u_hazard_detect (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .de_mem_read  (de_mem_read),
    .de_write_reg (de_write_reg),
    .load_use     (load_use)
  );

  // The XM access is outstanding until memory reports ready
  assign mem_stall = mem_req_xm && !mem_ready;

  // Next-state and per-stage strobes from state and hazard inputs
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    drain_d = drain_q;
    if (rst) begin
      ctrl.fd_flush = 1'b1;
      ctrl.de_flush = 1'b1;
      ctrl.mw_flush = 1'b1;
      state_d       = StRun;
    end else begin
      unique case (state_q)
        StRun, StMemWait: begin
          if (mem_stall) begin
            // Freeze everything up to XM; MW drains a bubble
            ctrl.mw_en    = 1'b1;
            ctrl.mw_flush = 1'b1;
            state_d       = StMemWait;
          end else if (hlt_xm) begin
            // Stop fetching and squash the younger instructions behind HLT
            ctrl.fd_en    = 1'b1;
            ctrl.de_en    = 1'b1;
            ctrl.xm_en    = 1'b1;
            ctrl.mw_en    = 1'b1;
            ctrl.fd_flush = 1'b1;
            ctrl.de_flush = 1'b1;
            drain_d       = DrainW'(DRAIN_CYCLES - 1);
            state_d       = StDrain;
          end else if (load_use) begin
            // Hold PC/FD, insert a bubble into DE; any branch re-resolves next cycle
            ctrl.de_en    = 1'b1;
            ctrl.xm_en    = 1'b1;
            ctrl.mw_en    = 1'b1;
            ctrl.de_flush = 1'b1;
            state_d       = StRun;
          end else begin
            ctrl.pc_en    = 1'b1;
            ctrl.fd_en    = 1'b1;
            ctrl.de_en    = 1'b1;
            ctrl.xm_en    = 1'b1;
            ctrl.mw_en    = 1'b1;
            ctrl.fd_flush = branch_taken;
            state_d       = StRun;
          end
        end
        StDrain: begin
          ctrl.xm_en = 1'b1;
          ctrl.mw_en = 1'b1;
          if (drain_q == '0) begin
            state_d = StHalted;
          end else begin
            drain_d = drain_q - DrainW'(1);
          end
        end
        StHalted: begin
          ctrl.halted = 1'b1;
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // State and drain counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Saturating count of cycles with the PC held, excluding the halted state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!ctrl.pc_en && (state_q != StHalted) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pc_en     = ctrl.pc_en;
  assign fd_en     = ctrl.fd_en;
  assign de_en     = ctrl.de_en;
  assign xm_en     = ctrl.xm_en;
  assign mw_en     = ctrl.mw_en;
  assign fd_flush  = ctrl.fd_flush;
  assign de_flush  = ctrl.de_flush;
  assign mw_flush  = ctrl.mw_flush;
  assign halted    = ctrl.halted;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Scoreboard bench for pipeline_hazard_control: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_pipeline_hazard_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rs, id_rt, de_write_reg;
  logic        id_uses_rs, id_uses_rt, de_mem_read;
  logic        branch_taken, hlt_xm, mem_req_xm, mem_ready;

  logic        pc_en, fd_en, de_en, xm_en, mw_en;
  logic        fd_flush, de_flush, mw_flush, halted;
  logic [15:0] stall_cnt;

  logic        s_pc_en, s_fd_en, s_de_en, s_xm_en, s_mw_en;
  logic        s_fd_flush, s_de_flush, s_mw_flush, s_halted;
  logic [3:0]  s_stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_control dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .de_mem_read(de_mem_read), .de_write_reg(de_write_reg),
    .branch_taken(branch_taken), .hlt_xm(hlt_xm), .mem_req_xm(mem_req_xm),
    .mem_ready(mem_ready), .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .xm_en(xm_en),
    .mw_en(mw_en), .fd_flush(fd_flush), .de_flush(de_flush), .mw_flush(mw_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy to exercise saturation in a reasonable number of cycles
  pipeline_hazard_control #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .de_mem_read(de_mem_read), .de_write_reg(de_write_reg),
    .branch_taken(branch_taken), .hlt_xm(hlt_xm), .mem_req_xm(mem_req_xm),
    .mem_ready(mem_ready), .pc_en(s_pc_en), .fd_en(s_fd_en), .de_en(s_de_en),
    .xm_en(s_xm_en), .mw_en(s_mw_en), .fd_flush(s_fd_flush), .de_flush(s_de_flush),
    .mw_flush(s_mw_flush), .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic [4:0]  en;    // {pc, fd, de, xm, mw}
    logic [2:0]  fl;    // {fd, de, mw}
    logic        hl;
    logic        chk;   // counter value is defined
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          applied = 0;
  int          miscompares = 0;
  int unsigned m_cnt = 0;
  int unsigned m_cnt4 = 0;
  logic        cnt_known = 1'b0;

  exp_t        mon_e;
  string       mon_n;
  logic [4:0]  act_en;
  logic [2:0]  act_fl;

  // Monitor: one expectation per cycle, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mon_e  = exp_q.pop_front();
        mon_n  = name_q.pop_front();
        act_en = {pc_en, fd_en, de_en, xm_en, mw_en};
        act_fl = {fd_flush, de_flush, mw_flush};
        applied++;
        if (act_en !== mon_e.en || act_fl !== mon_e.fl || halted !== mon_e.hl ||
            s_pc_en !== mon_e.en[4] ||
            (mon_e.chk && (stall_cnt !== mon_e.cnt || s_stall_cnt !== mon_e.cnt4))) begin
          miscompares++;
          $display("FAIL %s: got en=%b fl=%b halted=%b cnt=%0d cnt4=%0d, required en=%b fl=%b halted=%b cnt=%0d cnt4=%0d",
                   mon_n, act_en, act_fl, halted, stall_cnt, s_stall_cnt,
                   mon_e.en, mon_e.fl, mon_e.hl, mon_e.cnt, mon_e.cnt4);
        end
      end
    end
  end

  task automatic idle();
    rst = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    de_mem_read = 1'b0; de_write_reg = '0; branch_taken = 1'b0; hlt_xm = 1'b0;
    mem_req_xm = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use_rs3();
    de_mem_read = 1'b1; de_write_reg = 4'd3; id_rs = 4'd3; id_uses_rs = 1'b1;
  endtask

  // Push the expectation for the current input cycle, advance the stall-count model
  task automatic step(input string name, input logic [4:0] en, input logic [2:0] fl,
                      input logic hl);
    exp_t e;
    e.en = en; e.fl = fl; e.hl = hl; e.chk = cnt_known;
    e.cnt = 16'(m_cnt); e.cnt4 = 4'(m_cnt4);
    exp_q.push_back(e);
    name_q.push_back(name);
    if (rst) begin
      m_cnt = 0; m_cnt4 = 0; cnt_known = 1'b1;
    end else if (!en[4] && !hl) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset held three cycles
    step("rst0", 5'b00000, 3'b111, 1'b0);
    step("rst1", 5'b00000, 3'b111, 1'b0);
    step("rst2", 5'b00000, 3'b111, 1'b0);
    rst = 1'b0;
    step("run_idle", 5'b11111, 3'b000, 1'b0);
    // Load-use on rs, on rt, and two non-hazards
    load_use_rs3();
    step("lu_rs", 5'b00111, 3'b010, 1'b0);
    idle();
    step("after_lu", 5'b11111, 3'b000, 1'b0);
    de_mem_read = 1'b1; de_write_reg = 4'd5; id_rt = 4'd5; id_uses_rt = 1'b1;
    step("lu_rt", 5'b00111, 3'b010, 1'b0);
    de_write_reg = 4'd0; id_rt = 4'd0; id_rs = 4'd0; id_uses_rs = 1'b1;
    step("lu_r0", 5'b11111, 3'b000, 1'b0);
    de_write_reg = 4'd5; id_rt = 4'd5; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    step("lu_unused", 5'b11111, 3'b000, 1'b0);
    // Load-use beats branch; branch alone squashes FD
    idle(); load_use_rs3(); branch_taken = 1'b1;
    step("lu_br", 5'b00111, 3'b010, 1'b0);
    idle(); branch_taken = 1'b1;
    step("br", 5'b11111, 3'b100, 1'b0);
    idle();
    step("idle2", 5'b11111, 3'b000, 1'b0);
    // Memory wait for four cycles; beats load-use, branch and HLT
    load_use_rs3(); branch_taken = 1'b1; mem_req_xm = 1'b1;
    step("mw0", 5'b00001, 3'b001, 1'b0);
    idle(); mem_req_xm = 1'b1;
    step("mw1", 5'b00001, 3'b001, 1'b0);
    step("mw2", 5'b00001, 3'b001, 1'b0);
    hlt_xm = 1'b1;
    step("mw3_hlt", 5'b00001, 3'b001, 1'b0);
    hlt_xm = 1'b0; mem_ready = 1'b1;
    step("mw_done", 5'b11111, 3'b000, 1'b0);
    idle(); mem_req_xm = 1'b1; mem_ready = 1'b1;
    step("mem_1cyc", 5'b11111, 3'b000, 1'b0);
    idle();
    step("idle3", 5'b11111, 3'b000, 1'b0);
    // HLT: squash, two drain cycles, then halted until reset
    hlt_xm = 1'b1;
    step("hlt", 5'b01111, 3'b110, 1'b0);
    idle();
    step("drain0", 5'b00011, 3'b000, 1'b0);
    step("drain1", 5'b00011, 3'b000, 1'b0);
    step("halted0", 5'b00000, 3'b000, 1'b1);
    branch_taken = 1'b1; mem_req_xm = 1'b1; load_use_rs3();
    step("halted1", 5'b00000, 3'b000, 1'b1);
    idle();
    step("halted2", 5'b00000, 3'b000, 1'b1);
    rst = 1'b1;
    step("rst_halt", 5'b00000, 3'b111, 1'b0);
    rst = 1'b0;
    step("post_rst", 5'b11111, 3'b000, 1'b0);
    // Reset in the middle of a drain and of a memory stall
    hlt_xm = 1'b1;
    step("hlt2", 5'b01111, 3'b110, 1'b0);
    idle();
    step("drain_a", 5'b00011, 3'b000, 1'b0);
    rst = 1'b1;
    step("rst_drain", 5'b00000, 3'b111, 1'b0);
    rst = 1'b0;
    step("post_rst2", 5'b11111, 3'b000, 1'b0);
    mem_req_xm = 1'b1;
    step("mw_a", 5'b00001, 3'b001, 1'b0);
    rst = 1'b1;
    step("rst_mw", 5'b00000, 3'b111, 1'b0);
    idle();
    step("post_rst3", 5'b11111, 3'b000, 1'b0);
    // Twenty stall cycles: the 4-bit counter saturates at 15
    load_use_rs3();
    for (int i = 0; i < 20; i++) begin
      step("lu_sat", 5'b00111, 3'b010, 1'b0);
    end
    idle();
    step("sat_check", 5'b11111, 3'b000, 1'b0);
    step("sat_hold", 5'b11111, 3'b000, 1'b0);
    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
